// File: rtl/ped_request_unit.sv
// Pedestrian push-button front end for the traffic-light controller.
// Syncs and debounces BUTTON, holds KEY until P_G, then locks out.
//
// Ports:
//   CLOCK  in   system clock
//   RST    in   asynchronous active-low reset
//   BUTTON in   raw pedestrian button (async, bouncy, active-high)
//   P_G    in   pedestrian green from controller (async)
//   P_R    in   pedestrian red from controller (async)
//   KEY    out  crossing request to controller (registered level)
//   WAIT   out  request-pending lamp (registered)
//   FAULT  out  sticky no-acknowledge flag (registered)
module ped_request_unit #(
    parameter int DEB_CYCLES     = 4,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int MAX_WAIT       = 1000,
    parameter int CNT_W          = 16
) (
    input  logic CLOCK,
    input  logic RST,
    input  logic BUTTON,
    input  logic P_G,
    input  logic P_R,
    output logic KEY,
    output logic WAIT,
    output logic FAULT
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REQUEST    = 3'd1,
        ST_FAULT_WAIT = 3'd2,
        ST_CROSSING   = 3'd3,
        ST_LOCKOUT    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    logic b_m, b_s, g_m, g_s, r_m, r_s;
    logic deb, deb_d, press;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] wait_cnt, wait_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_nxt;
    state_t state, state_nxt;
    logic key_nxt, lamp_nxt, fault_nxt;

    // Two-flop synchronisers for all asynchronous inputs.
    always_ff @(posedge CLOCK or negedge RST) begin
        if (!RST) begin
            b_m <= 1'b0;
            b_s <= 1'b0;
            g_m <= 1'b0;
            g_s <= 1'b0;
            r_m <= 1'b0;
            r_s <= 1'b0;
        end else begin
            b_m <= BUTTON;
            b_s <= b_m;
            g_m <= P_G;
            g_s <= g_m;
            r_m <= P_R;
            r_s <= r_m;
        end
    end

    // Debounce: a new level must differ from deb for DEB_CYCLES edges.
    always_ff @(posedge CLOCK or negedge RST) begin
        if (!RST) begin
            deb     <= 1'b0;
            deb_d   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            deb_d <= deb;
            if (b_s == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= b_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign press = deb & ~deb_d;

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        lock_nxt  = lock_cnt;
        fault_nxt = FAULT;
        case (state)
            ST_IDLE: begin
                // press has priority over a stale green in IDLE
                if (press) begin
                    state_nxt = ST_REQUEST;
                    wait_nxt  = '0;
                end
            end
            ST_REQUEST: begin
                if (g_s) begin
                    state_nxt = ST_CROSSING;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_FAULT_WAIT;
                    fault_nxt = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            ST_FAULT_WAIT: begin
                if (g_s) state_nxt = ST_CROSSING;
            end
            ST_CROSSING: begin
                // green blinks at crossing end; only red ends it
                if (r_s) begin
                    state_nxt = ST_LOCKOUT;
                    lock_nxt  = LOCK_LAST;
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    lock_nxt = lock_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        key_nxt  = (state_nxt == ST_REQUEST) ||
                   (state_nxt == ST_FAULT_WAIT);
        lamp_nxt = key_nxt;
    end

    always_ff @(posedge CLOCK or negedge RST) begin
        if (!RST) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            lock_cnt <= '0;
            KEY      <= 1'b0;
            WAIT     <= 1'b0;
            FAULT    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            lock_cnt <= lock_nxt;
            KEY      <= key_nxt;
            WAIT     <= lamp_nxt;
            FAULT    <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_ped_request_unit.sv
// Bench for ped_request_unit: directed scenarios plus random stimulus,
// checked every cycle against a timestamp-based behavioural model.
module tb_ped_request_unit;

    localparam int DEB   = 4;
    localparam int LOCKN = 16;
    localparam int MAXW  = 50;

    logic clk, rst_n, button, p_g, p_r;
    logic key, lamp, fault;

    int tests = 0;
    int fails = 0;

    ped_request_unit #(
        .DEB_CYCLES(DEB),
        .LOCKOUT_CYCLES(LOCKN),
        .MAX_WAIT(MAXW),
        .CNT_W(16)
    ) dut (
        .CLOCK(clk),
        .RST(rst_n),
        .BUTTON(button),
        .P_G(p_g),
        .P_R(p_r),
        .KEY(key),
        .WAIT(lamp),
        .FAULT(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int { M_IDLE, M_REQ, M_FW, M_CROSS, M_LOCK } mmode_t;

    mmode_t m_mode;
    int     e, req_t, lk_t;
    bit     m_fault, m_deb, m_press;
    bit     m_bm, m_bs, m_gm, m_gs, m_rm, m_rs;
    bit     hist[$];

    task automatic model_reset();
        m_mode  = M_IDLE;
        e       = 0;
        req_t   = 0;
        lk_t    = 0;
        m_fault = 0;
        m_deb   = 0;
        m_press = 0;
        m_bm = 0; m_bs = 0;
        m_gm = 0; m_gs = 0;
        m_rm = 0; m_rs = 0;
        hist.delete();
    endtask

    task automatic model_step();
        bit old_deb, all_diff;
        e++;
        case (m_mode)
            M_IDLE:  if (m_press) begin m_mode = M_REQ; req_t = e; end
            M_REQ: begin
                if (m_gs) m_mode = M_CROSS;
                else if (e - req_t == MAXW) begin
                    m_mode = M_FW;
                    m_fault = 1;
                end
            end
            M_FW:    if (m_gs) m_mode = M_CROSS;
            M_CROSS: if (m_rs) begin m_mode = M_LOCK; lk_t = e; end
            M_LOCK:  if (e - lk_t == LOCKN) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
        // deb flips once DEB consecutive synced samples all differ from it
        hist.push_back(m_bs);
        if (hist.size() > DEB) void'(hist.pop_front());
        old_deb = m_deb;
        if (hist.size() == DEB) begin
            all_diff = 1;
            foreach (hist[i]) if (hist[i] == m_deb) all_diff = 0;
            if (all_diff) begin
                m_deb = ~m_deb;
                hist.delete();
            end
        end
        m_press = m_deb & ~old_deb;
        m_bs = m_bm; m_bm = button;
        m_gs = m_gm; m_gm = p_g;
        m_rs = m_rm; m_rm = p_r;
    endtask

    task automatic check(input string tag);
        bit exp_key;
        exp_key = (m_mode == M_REQ) || (m_mode == M_FW);
        tests++;
        assert (key === exp_key) else begin
            fails++;
            $error("FAIL %s key got %b exp %b", tag, key, exp_key);
        end
        tests++;
        assert (lamp === exp_key) else begin
            fails++;
            $error("FAIL %s wait got %b exp %b", tag, lamp, exp_key);
        end
        tests++;
        assert (fault === m_fault) else begin
            fails++;
            $error("FAIL %s fault got %b exp %b", tag, fault, m_fault);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check(tag);
    endtask

    // Called right after tick: reset pulse lands between clock edges.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        tests++;
        assert ({key, lamp, fault} === 3'b000) else begin
            fails++;
            $error("FAIL %s async_reset got %b exp 000",
                   tag, {key, lamp, fault});
        end
        #2;
        rst_n = 1'b1;
    endtask

    // sel: 0=key 1=fault. n = ticks taken, -1 if bound expired.
    task automatic wait_for(input string tag, input int sel,
                            input bit val, input int maxn,
                            output int n);
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < maxn) begin
            tick(tag);
            n++;
            hit = ((sel == 0) ? key : fault) === val;
        end
        if (!hit) n = -1;
    endtask

    task automatic expect_n(input string tag, input int got,
                            input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s latency got %0d exp %0d", tag, got, exp);
        end
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        button = 1'b0;
        p_g    = 1'b0;
        p_r    = 1'b0;
        model_reset();
        #12;
        check("reset");
        rst_n = 1'b1;

        // clean press: KEY at edge 7
        button = 1'b1;
        wait_for("press", 0, 1'b1, 20, n);
        expect_n("press_lat", n, DEB + 3);
        repeat (13) tick("press_hold");
        do_reset("t1");
        button = 1'b0;

        // bounce of period 2+2 cycles
        for (int i = 0; i < 30; i++) begin
            button = ((i / 2) % 2 == 0);
            tick("bounce");
        end
        button = 1'b0;
        repeat (10) tick("bounce_end");

        // full handshake
        button = 1'b1;
        wait_for("hs_press", 0, 1'b1, 20, n);
        expect_n("hs_lat", n, DEB + 3);
        button = 1'b0;
        p_g = 1'b1;
        wait_for("hs_green", 0, 1'b0, 10, n);
        expect_n("hs_ack", n, 3);
        repeat (37) tick("hs_cross");
        p_g = 1'b0;
        p_r = 1'b1;
        repeat (3) tick("hs_red");
        // five cycles into lockout: press is discarded
        repeat (5) tick("lock");
        button = 1'b1;
        repeat (10) tick("lock_press");
        button = 1'b0;
        repeat (20) tick("lock_rel");
        tests++;
        assert (key === 1'b0) else begin
            fails++;
            $error("FAIL lock_discard key got %b exp 0", key);
        end
        button = 1'b1;
        wait_for("fresh", 0, 1'b1, 20, n);
        expect_n("fresh_lat", n, DEB + 3);
        button = 1'b0;
        p_r = 1'b0;
        do_reset("t4");

        // timeout
        button = 1'b1;
        wait_for("to_press", 0, 1'b1, 20, n);
        button = 1'b0;
        wait_for("to_wait", 1, 1'b1, MAXW + 10, n);
        expect_n("to_lat", n, MAXW);
        tests++;
        assert (key === 1'b1) else begin
            fails++;
            $error("FAIL to_key got %b exp 1", key);
        end
        repeat (7) tick("fw_hold");
        p_g = 1'b1;
        wait_for("to_ack", 0, 1'b0, 10, n);
        expect_n("to_ack_lat", n, 3);
        repeat (5) tick("fault_sticky");
        p_g = 1'b0;
        do_reset("t5");

        // async reset mid-request, button held through
        button = 1'b1;
        wait_for("ar_press", 0, 1'b1, 20, n);
        do_reset("t6");
        wait_for("ar_again", 0, 1'b1, 20, n);
        expect_n("ar_lat", n, DEB + 3);
        button = 1'b0;
        do_reset("t6b");

        // random segments
        for (int s = 0; s < 300; s++) begin
            int len;
            len = $urandom_range(1, 14);
            if ($urandom_range(0, 3) == 0) button = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) p_g = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) p_r = $urandom_range(0, 1);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) == 0) button = ~button;
                tick("rand");
            end
            if ($urandom_range(0, 99) == 0) do_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ped_request_unit.md
Name: ped_request_unit

Overview:
- Pedestrian push-button front end that drives the KEY input of the traffic-light controller.
- Synchronises and debounces the raw button, then latches one crossing request and holds KEY until the controller acknowledges by lighting P_G.
- Tracks the crossing until P_R returns, then applies a lockout before a new request is accepted.
- Drives the "WAIT" indicator lamp and a sticky FAULT flag if the controller never answers.

Parameters:
- DEB_CYCLES, 4, consecutive stable CLOCK cycles required to accept a new button level (>=1).
- LOCKOUT_CYCLES, 16, cycles after crossing end during which presses are discarded (>=1).
- MAX_WAIT, 1000, cycles in REQUEST before FAULT asserts.
- CNT_W, 16, width of the internal counters; must hold MAX_WAIT and LOCKOUT_CYCLES.

Ports:
- CLOCK  in  1  system clock, same clock as the controller's CLOCK input.
- RST  in  1  asynchronous active-low reset.
- BUTTON  in  1  raw pedestrian button, asynchronous, bouncy, active-high.
- P_G  in  1  pedestrian green from controller, asynchronous to CLOCK domain use; blinks during crossing end.
- P_R  in  1  pedestrian red from controller.
- KEY  out  1  crossing request to controller, level, registered.
- WAIT  out  1  "request pending" indicator lamp, registered.
- FAULT  out  1  sticky "no acknowledge within MAX_WAIT" flag, registered.

Behaviour:
- Reset (RST=0, async): KEY=0, WAIT=0, FAULT=0. State=IDLE. Synchronisers, debounced level and all counters are 0.
- Synchronisers: BUTTON, P_G and P_R each pass through a 2-flop synchroniser. Only the synchronised copies are used below (b_s, g_s, r_s).
- Debounce:
  - deb_cnt clears whenever b_s==deb.
  - Otherwise deb_cnt increments.
  - When b_s!=deb and deb_cnt==DEB_CYCLES-1: deb<=b_s and deb_cnt<=0 on the same edge.
  - press = deb rising (0->1), a one-cycle event.
- Latency: counting the first edge that samples BUTTON=1 as edge 1, deb rises at edge DEB_CYCLES+2 and KEY rises at edge DEB_CYCLES+3 (edge 7 for the default).
- A bounce shorter than DEB_CYCLES stable cycles never changes deb.
- State machine (registered outputs follow the state entered on each edge):
  - IDLE: KEY=0, WAIT=0. press -> REQUEST, and wait_cnt<=0.
  - REQUEST: KEY=1, WAIT=1.
    - g_s==1 -> CROSSING.
    - Else if wait_cnt==MAX_WAIT-1 -> FAULT_WAIT, and FAULT<=1.
    - Else wait_cnt increments.
  - FAULT_WAIT: KEY=1, WAIT=1, FAULT held 1. g_s==1 -> CROSSING.
  - CROSSING: KEY=0, WAIT=0. r_s==1 -> LOCKOUT, and lock_cnt<=LOCKOUT_CYCLES-1.
  - LOCKOUT: KEY=0, WAIT=0.
    - lock_cnt==0 -> IDLE.
    - Else lock_cnt decrements.
  - Unused state encodings -> IDLE.
- P_G blinking during crossing end has no effect: CROSSING exits only on r_s.
- press in REQUEST, FAULT_WAIT, CROSSING or LOCKOUT is discarded, not queued.
- A button held continuously through LOCKOUT does not re-request. A new deb rising edge is required.
- press and g_s==1 in IDLE on the same edge: press wins -> REQUEST. The next edge then moves to CROSSING if g_s is still 1.
- FAULT is cleared only by reset.
- Reset asserted mid-operation (any state) forces IDLE and all outputs to 0 immediately, with no clock required.
- Counters saturate, never wrap: wait_cnt stops at MAX_WAIT-1, lock_cnt stops at 0.

Test Plan:
1. Clean press: RST released, BUTTON=1 held 20 cycles, P_G=0 -> KEY=1 and WAIT=1 at edge 7 after BUTTON sampled high; both stay 1.
2. Bounce rejection: BUTTON toggles 1/0 every 2 cycles for 30 cycles, then stays 0 -> KEY, WAIT never assert; deb stays 0.
3. Full handshake: request pending, P_G=1 and P_R=0 for 40 cycles, then P_G=0 and P_R=1.
   - KEY and WAIT drop 3 edges after P_G rises.
   - Unit enters LOCKOUT 3 edges after P_R rises.
   - Unit returns to IDLE 16 edges later.
4. Lockout discard: second clean press 5 cycles into LOCKOUT, held 10 cycles and released -> KEY stays 0. A fresh press after IDLE -> KEY=1 at the standard latency.
5. Timeout: MAX_WAIT=50, press with P_G held 0 -> FAULT=1 exactly 50 edges after REQUEST is entered, with KEY=1. P_G=1 later -> KEY=0, FAULT remains 1.
6. Async reset mid-request: KEY=1 in REQUEST, pull RST=0 between clock edges -> KEY, WAIT, FAULT all 0 immediately. After RST=1 with BUTTON still held, a new request needs the full debounce latency.
